// File: rtl/riscv_apu_disp_fifo.sv
// APU dispatcher with a DEPTH-entry in-order queue of outstanding write-back addresses.
// Issues requests, stalls on capacity/latency-type/grant, and flags RAW/WAW hazards.
module riscv_apu_disp_fifo #(
  parameter int DEPTH   = 4,
  parameter int WADDR_W = 6,
  parameter int N_RD    = 3,
  parameter int N_WR    = 2,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [1:0]              apu_lat_i,
  input  logic [WADDR_W-1:0]      apu_waddr_i,
  output logic [WADDR_W-1:0]      apu_waddr_o,
  output logic                    apu_wvalid_o,
  output logic                    apu_multicycle_o,
  output logic                    apu_singlecycle_o,
  output logic                    active_o,
  output logic [CNT_W-1:0]        occupancy_o,
  output logic                    stall_o,
  input  logic [N_RD*WADDR_W-1:0] read_regs_i,
  input  logic [N_RD-1:0]         read_regs_valid_i,
  output logic                    read_dep_o,
  input  logic [N_WR*WADDR_W-1:0] write_regs_i,
  input  logic [N_WR-1:0]         write_regs_valid_i,
  output logic                    write_dep_o,
  output logic                    perf_type_o,
  output logic                    perf_cont_o,
  output logic                    perf_full_o,
  output logic                    err_o,
  output logic                    apu_master_req_o,
  output logic                    apu_master_ready_o,
  input  logic                    apu_master_gnt_i,
  input  logic                    apu_master_valid_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WADDR_W-1:0] ent_q [DEPTH];
  logic [DEPTH-1:0]   ent_vld_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         lat_q;
  logic               err_q;

  logic active, stall_full, stall_type, valid_req, stall_nack, accepted;
  logic ret_req, ret_head, push, pop, spurious, req_dep_cand;
  logic rd_hit, wr_hit;

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign active     = (cnt_q != '0);
  assign stall_full = (cnt_q == CNT_W'(DEPTH));
  assign stall_type = enable_i & active &
                      ((apu_lat_i == 2'd1) |
                       ((apu_lat_i == 2'd2) & (lat_q == 2'd3)) |
                       (apu_lat_i == 2'd3));
  assign valid_req  = enable_i & ~stall_full & ~stall_type;
  assign stall_nack = valid_req & ~apu_master_gnt_i;
  assign accepted   = valid_req & apu_master_gnt_i;

  // A response on an empty queue either completes the op issued this cycle or is spurious.
  assign ret_req      = accepted & apu_master_valid_i & ~active;
  assign ret_head     = apu_master_valid_i & active;
  assign push         = accepted & ~ret_req;
  assign pop          = ret_head;
  assign spurious     = apu_master_valid_i & ~active & ~ret_req;
  assign req_dep_cand = valid_req & ~ret_req;

  assign stall_o            = stall_full | stall_type | stall_nack;
  assign apu_master_req_o   = valid_req;
  assign apu_master_ready_o = 1'b1;
  assign apu_wvalid_o       = ret_req | ret_head;
  assign apu_waddr_o        = ret_req  ? apu_waddr_i :
                              ret_head ? ent_q[rd_ptr_q] : '0;
  assign apu_multicycle_o   = (lat_q == 2'd3);
  assign apu_singlecycle_o  = ~active;
  assign active_o           = active;
  assign occupancy_o        = cnt_q;
  assign perf_type_o        = stall_type;
  assign perf_cont_o        = stall_nack;
  assign perf_full_o        = enable_i & stall_full;
  assign err_o              = err_q;

  // The retiring head no longer counts as a hazard in the cycle it writes back.
  always_comb begin
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    for (int p = 0; p < N_RD; p++) begin
      if (read_regs_valid_i[p]) begin
        if (req_dep_cand && (read_regs_i[p*WADDR_W +: WADDR_W] == apu_waddr_i)) rd_hit = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
          if (ent_vld_q[e] && !(ret_head && (PTR_W'(e) == rd_ptr_q)) &&
              (ent_q[e] == read_regs_i[p*WADDR_W +: WADDR_W])) rd_hit = 1'b1;
        end
      end
    end
    for (int p = 0; p < N_WR; p++) begin
      if (write_regs_valid_i[p]) begin
        if (req_dep_cand && (write_regs_i[p*WADDR_W +: WADDR_W] == apu_waddr_i)) wr_hit = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
          if (ent_vld_q[e] && !(ret_head && (PTR_W'(e) == rd_ptr_q)) &&
              (ent_q[e] == write_regs_i[p*WADDR_W +: WADDR_W])) wr_hit = 1'b1;
        end
      end
    end
  end

  assign read_dep_o  = rd_hit;
  assign write_dep_o = wr_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      ent_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      lat_q     <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      if (push) begin
        ent_q[wr_ptr_q]     <= apu_waddr_i;
        ent_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        ent_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q            <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (accepted) lat_q <= apu_lat_i;
      if (spurious) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_apu_disp_fifo.sv
// Scenario-based bench for riscv_apu_disp_fifo; expected write-back addresses flow through a queue.
module tb_riscv_apu_disp_fifo;
  localparam int DEPTH   = 4;
  localparam int WADDR_W = 6;
  localparam int N_RD    = 3;
  localparam int N_WR    = 2;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    enable_i;
  logic [1:0]              apu_lat_i;
  logic [WADDR_W-1:0]      apu_waddr_i;
  logic [WADDR_W-1:0]      apu_waddr_o;
  logic                    apu_wvalid_o;
  logic                    apu_multicycle_o;
  logic                    apu_singlecycle_o;
  logic                    active_o;
  logic [CNT_W-1:0]        occupancy_o;
  logic                    stall_o;
  logic [N_RD*WADDR_W-1:0] read_regs_i;
  logic [N_RD-1:0]         read_regs_valid_i;
  logic                    read_dep_o;
  logic [N_WR*WADDR_W-1:0] write_regs_i;
  logic [N_WR-1:0]         write_regs_valid_i;
  logic                    write_dep_o;
  logic                    perf_type_o;
  logic                    perf_cont_o;
  logic                    perf_full_o;
  logic                    err_o;
  logic                    apu_master_req_o;
  logic                    apu_master_ready_o;
  logic                    apu_master_gnt_i;
  logic                    apu_master_valid_i;

  riscv_apu_disp_fifo #(.DEPTH(DEPTH), .WADDR_W(WADDR_W), .N_RD(N_RD), .N_WR(N_WR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .apu_lat_i(apu_lat_i),
    .apu_waddr_i(apu_waddr_i), .apu_waddr_o(apu_waddr_o), .apu_wvalid_o(apu_wvalid_o),
    .apu_multicycle_o(apu_multicycle_o), .apu_singlecycle_o(apu_singlecycle_o),
    .active_o(active_o), .occupancy_o(occupancy_o), .stall_o(stall_o),
    .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i), .read_dep_o(read_dep_o),
    .write_regs_i(write_regs_i), .write_regs_valid_i(write_regs_valid_i), .write_dep_o(write_dep_o),
    .perf_type_o(perf_type_o), .perf_cont_o(perf_cont_o), .perf_full_o(perf_full_o),
    .err_o(err_o), .apu_master_req_o(apu_master_req_o), .apu_master_ready_o(apu_master_ready_o),
    .apu_master_gnt_i(apu_master_gnt_i), .apu_master_valid_i(apu_master_valid_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WADDR_W-1:0] sb_q[$];
  logic [WADDR_W-1:0] exp_a;

  task automatic idle();
    enable_i = 1'b0; apu_lat_i = 2'd0; apu_waddr_i = '0;
    apu_master_gnt_i = 1'b0; apu_master_valid_i = 1'b0;
    read_regs_i = '0; read_regs_valid_i = '0;
    write_regs_i = '0; write_regs_valid_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic issue(input logic [1:0] lat, input logic [WADDR_W-1:0] a);
    idle(); enable_i = 1'b1; apu_lat_i = lat; apu_waddr_i = a; apu_master_gnt_i = 1'b1;
  endtask

  task automatic test_reset();
    idle(); rst_ni = 1'b0;
    #4;
    n_checks++; if (occupancy_o !== '0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    n_checks++; if (apu_singlecycle_o !== 1'b1) begin n_fail++; $display("FAIL reset_single: got %b want 1", apu_singlecycle_o); end
    n_checks++; if (apu_master_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", apu_master_ready_o); end
    n_checks++;
    if ({stall_o, apu_master_req_o, apu_wvalid_o, err_o, active_o, apu_multicycle_o, read_dep_o, write_dep_o,
         perf_type_o, perf_cont_o, perf_full_o} !== 11'b0 || apu_waddr_o !== '0) begin
      n_fail++; $display("FAIL reset_zero_outputs: some output nonzero, waddr_o=%0d stall=%b err=%b", apu_waddr_o, stall_o, err_o);
    end
    next_cycle(); rst_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_bypass();
    issue(2'd0, 6'd5); apu_master_valid_i = 1'b1;
    sb_q.push_back(6'd5);
    #4;
    n_checks++; if (apu_wvalid_o !== 1'b1) begin n_fail++; $display("FAIL bypass_wvalid: got %b want 1", apu_wvalid_o); end
    if (apu_wvalid_o === 1'b1 && sb_q.size() > 0) begin
      exp_a = sb_q.pop_front();
      n_checks++; if (apu_waddr_o !== exp_a) begin n_fail++; $display("FAIL bypass_waddr: got %0d want %0d", apu_waddr_o, exp_a); end
    end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL bypass_stall: got %b want 0", stall_o); end
    next_cycle(); idle(); #4;
    n_checks++; if (occupancy_o !== '0) begin n_fail++; $display("FAIL bypass_occ: got %0d want 0", occupancy_o); end
    next_cycle();
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= DEPTH; i++) begin
      issue(2'd2, WADDR_W'(i)); #4;
      n_checks++; if (apu_master_req_o !== 1'b1 || stall_o !== 1'b0) begin
        n_fail++; $display("FAIL fill_req%0d: got req=%b stall=%b want req=1 stall=0", i, apu_master_req_o, stall_o);
      end
      sb_q.push_back(WADDR_W'(i));
      next_cycle();
    end
    issue(2'd2, 6'd5); #4;
    n_checks++; if (occupancy_o !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL full_occ: got %0d want %0d", occupancy_o, DEPTH); end
    n_checks++; if (stall_o !== 1'b1 || perf_full_o !== 1'b1 || apu_master_req_o !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got stall=%b perf_full=%b req=%b want 1 1 0", stall_o, perf_full_o, apu_master_req_o);
    end
    next_cycle();
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); apu_master_valid_i = 1'b1; #4;
      n_checks++; if (occupancy_o !== CNT_W'(DEPTH - i)) begin n_fail++; $display("FAIL drain_occ%0d: got %0d want %0d", i, occupancy_o, DEPTH - i); end
      n_checks++;
      if (apu_wvalid_o !== 1'b1 || sb_q.size() == 0) begin
        n_fail++; $display("FAIL drain_wvalid%0d: got %b want 1 (expected queue size %0d)", i, apu_wvalid_o, sb_q.size());
      end else begin
        exp_a = sb_q.pop_front();
        if (apu_waddr_o !== exp_a) begin n_fail++; $display("FAIL drain_waddr%0d: got %0d want %0d", i, apu_waddr_o, exp_a); end
      end
      next_cycle();
    end
    idle(); #4;
    n_checks++; if (occupancy_o !== '0 || apu_singlecycle_o !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty: got occ=%0d single=%b want 0 1", occupancy_o, apu_singlecycle_o);
    end
    next_cycle();
  endtask

  task automatic test_type_stall();
    issue(2'd3, 6'd10); sb_q.push_back(6'd10);
    next_cycle();
    issue(2'd2, 6'd11); #4;
    n_checks++; if (apu_multicycle_o !== 1'b1) begin n_fail++; $display("FAIL type_multicycle: got %b want 1", apu_multicycle_o); end
    n_checks++; if (stall_o !== 1'b1 || perf_type_o !== 1'b1 || apu_master_req_o !== 1'b0) begin
      n_fail++; $display("FAIL type_lat2: got stall=%b perf_type=%b req=%b want 1 1 0", stall_o, perf_type_o, apu_master_req_o);
    end
    apu_lat_i = 2'd3; #1;
    n_checks++; if (stall_o !== 1'b1 || perf_type_o !== 1'b1 || apu_master_req_o !== 1'b0) begin
      n_fail++; $display("FAIL type_lat3: got stall=%b perf_type=%b req=%b want 1 1 0", stall_o, perf_type_o, apu_master_req_o);
    end
    next_cycle();
    idle(); apu_master_valid_i = 1'b1; #4;
    n_checks++;
    if (apu_wvalid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL type_retire: got wvalid=%b want 1", apu_wvalid_o);
    end else begin
      exp_a = sb_q.pop_front();
      if (apu_waddr_o !== exp_a) begin n_fail++; $display("FAIL type_retire_waddr: got %0d want %0d", apu_waddr_o, exp_a); end
    end
    next_cycle();
  endtask

  task automatic test_deps();
    issue(2'd2, 6'd7); sb_q.push_back(6'd7); next_cycle();
    issue(2'd2, 6'd9); sb_q.push_back(6'd9); next_cycle();
    idle(); read_regs_i[WADDR_W +: WADDR_W] = 6'd9; read_regs_valid_i = 3'b010;
    write_regs_i[0 +: WADDR_W] = 6'd9; write_regs_valid_i = 2'b01; #2;
    n_checks++; if (read_dep_o !== 1'b1) begin n_fail++; $display("FAIL dep_read9: got %b want 1", read_dep_o); end
    n_checks++; if (write_dep_o !== 1'b1) begin n_fail++; $display("FAIL dep_write9: got %b want 1", write_dep_o); end
    read_regs_i[WADDR_W +: WADDR_W] = 6'd7; apu_master_valid_i = 1'b1; #1;
    n_checks++; if (read_dep_o !== 1'b0) begin n_fail++; $display("FAIL dep_read7_retiring: got %b want 0", read_dep_o); end
    write_regs_valid_i = 2'b00; read_regs_i[WADDR_W +: WADDR_W] = 6'd20;
    enable_i = 1'b1; apu_lat_i = 2'd2; apu_waddr_i = 6'd20; apu_master_gnt_i = 1'b0; #1;
    n_checks++; if (read_dep_o !== 1'b1 || perf_cont_o !== 1'b1) begin
      n_fail++; $display("FAIL dep_read_req: got dep=%b cont=%b want 1 1", read_dep_o, perf_cont_o);
    end
    enable_i = 1'b0; read_regs_i[WADDR_W +: WADDR_W] = 6'd9; #1;
    n_checks++; if (read_dep_o !== 1'b1) begin n_fail++; $display("FAIL dep_read9_retiring7: got %b want 1", read_dep_o); end
    n_checks++;
    if (apu_wvalid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL dep_retire7: got wvalid=%b want 1", apu_wvalid_o);
    end else begin
      exp_a = sb_q.pop_front();
      if (apu_waddr_o !== exp_a) begin n_fail++; $display("FAIL dep_retire7_waddr: got %0d want %0d", apu_waddr_o, exp_a); end
    end
    next_cycle();
    apu_master_valid_i = 1'b0; read_regs_i[WADDR_W +: WADDR_W] = 6'd7; #2;
    n_checks++; if (read_dep_o !== 1'b0) begin n_fail++; $display("FAIL dep_read7_gone: got %b want 0", read_dep_o); end
    idle(); apu_master_valid_i = 1'b1; #2;
    n_checks++;
    if (apu_wvalid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL dep_retire9: got wvalid=%b want 1", apu_wvalid_o);
    end else begin
      exp_a = sb_q.pop_front();
      if (apu_waddr_o !== exp_a) begin n_fail++; $display("FAIL dep_retire9_waddr: got %0d want %0d", apu_waddr_o, exp_a); end
    end
    next_cycle();
  endtask

  task automatic test_error_reset();
    idle(); apu_master_valid_i = 1'b1; #4;
    n_checks++; if (apu_wvalid_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_spurious_now: got wvalid=%b err=%b want 0 0", apu_wvalid_o, err_o);
    end
    next_cycle(); idle(); #4;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err_o); end
    next_cycle(); #4;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_held: got %b want 1", err_o); end
    next_cycle();
    for (int i = 0; i < 3; i++) begin issue(2'd2, WADDR_W'(30 + i)); next_cycle(); end
    idle(); #2;
    n_checks++; if (occupancy_o !== CNT_W'(3)) begin n_fail++; $display("FAIL rst_pre_occ: got %0d want 3", occupancy_o); end
    rst_ni = 1'b0; #1;
    n_checks++; if (occupancy_o !== '0 || err_o !== 1'b0 || active_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got occ=%0d err=%b active=%b want 0 0 0", occupancy_o, err_o, active_o);
    end
    next_cycle(); rst_ni = 1'b1; next_cycle();
    apu_master_valid_i = 1'b1; #4;
    n_checks++; if (apu_wvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_stale_wvalid: got %b want 0", apu_wvalid_o); end
    next_cycle(); idle(); #4;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL rst_stale_err: got %b want 1", err_o); end
    next_cycle();
  endtask

  initial begin
    idle(); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_reset();
    test_bypass();
    test_fill_full();
    test_drain();
    test_type_stall();
    test_deps();
    test_error_reset();
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_apu_disp_fifo.md
# riscv_apu_disp_fifo

Parametrised APU dispatcher that replaces the fixed two-entry in-flight tracking with a DEPTH-entry in-order queue of outstanding write-back addresses. It sits between the ID stage and the APU interconnect. It issues requests, stalls on capacity, latency-type conflicts or missing grant, and reports read/write hazards against every outstanding destination register. It also adds an explicit write-back valid, an occupancy count and a sticky protocol-error flag.

## Interface
- DEPTH, 4, max outstanding multicycle ops; legal 2..8
- WADDR_W, 6, register-address width
- N_RD, 3, number of read-dependency ports
- N_WR, 2, number of write-dependency ports
- CNT_W, $clog2(DEPTH+1), occupancy width (derived)

- clk_i  in  1  single clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  ID requests an APU op
- apu_lat_i  in  2  latency class: 0/1 single, 2 fixed multi, 3 variable
- apu_waddr_i  in  WADDR_W  destination of requested op
- apu_waddr_o  out  WADDR_W  write-back address
- apu_wvalid_o  out  1  write-back this cycle
- apu_multicycle_o  out  1  last accepted lat == 3
- apu_singlecycle_o  out  1  queue empty
- active_o  out  1  queue non-empty
- occupancy_o  out  CNT_W  entries outstanding
- stall_o  out  1  stall ID
- read_regs_i  in  N_RD*WADDR_W  packed read registers; port k at bits [k*WADDR_W +: WADDR_W]
- read_regs_valid_i  in  N_RD  per-port valid
- read_dep_o  out  1  RAW hazard
- write_regs_i  in  N_WR*WADDR_W  packed write registers
- write_regs_valid_i  in  N_WR  per-port valid
- write_dep_o  out  1  WAW hazard
- perf_type_o  out  1  type-stall event
- perf_cont_o  out  1  grant-contention event
- perf_full_o  out  1  capacity-stall event
- err_o  out  1  sticky: response with nothing outstanding
- apu_master_req_o  out  1  request
- apu_master_ready_o  out  1  always 1
- apu_master_gnt_i  in  1  grant
- apu_master_valid_i  in  1  response

## Operation
- Control terms:
  - stall_full = (count == DEPTH)
  - stall_type = enable_i & active & (lat_i==1 | (lat_i==2 & lat_q==3) | lat_i==3)
  - valid_req = enable_i & !stall_full & !stall_type
  - stall_nack = valid_req & !gnt
  - stall_o = stall_full | stall_type | stall_nack
- apu_master_req_o = valid_req; accepted = valid_req & gnt.
- Bypass: ret_req = accepted & valid_i & count==0. No push; apu_waddr_o = apu_waddr_i.
- Head return: ret_head = valid_i & count>0. Pop the head; apu_waddr_o = head addr.
- apu_wvalid_o = ret_req | ret_head. apu_waddr_o = 0 when neither is asserted.
- Push: accepted & !ret_req writes apu_waddr_i at the tail.
- Push and pop in the same cycle: count unchanged; both pointers advance modulo DEPTH.
- Push is never possible at full (stall_full blocks valid_req).
- lat_q (reset 0) loads apu_lat_i on accepted only.
- Dependencies:
  - read_dep_o is set if any valid read port matches either of:
    - apu_waddr_i while valid_req & !ret_req
    - any occupied entry, excluding the head when ret_head
  - write_dep_o: same rule applied to the write ports.
- Spurious response: valid_i & count==0 & !ret_req sets err_o. The response is ignored (no wvalid). err_o clears only on reset.
- Perf outputs:
  - perf_type_o = stall_type
  - perf_cont_o = stall_nack
  - perf_full_o = enable_i & stall_full

## Timing
- Reset (async, immediate):
  - count = 0, pointers = 0, entries = 0, lat_q = 0, err_o = 0
  - Outputs with inputs low: all 0 except apu_singlecycle_o = 1 and apu_master_ready_o = 1.
- All outputs are combinational from registered state and current inputs. State updates on the next rising edge.
- Single-cycle op on an empty queue: request, grant, response and write-back all in cycle N.
- Multicycle op: accepted in cycle N; occupancy_o and active_o rise in N+1; write-back appears in the cycle valid_i is seen.
- Responses are strictly in order: the head always retires first.
- Reset asserted mid-operation discards all entries. Responses after reset release count as spurious.

## Test plan
- Empty queue, enable, lat=0, waddr=5, gnt=1, valid=1 same cycle -> wvalid=1, waddr_o=5, occupancy stays 0, stall_o=0.
- Four lat=2 ops (waddr 1,2,3,4), gnt=1, no valid (DEPTH=4) -> occupancy 4; fifth enable gives stall_o=1, perf_full_o=1, req_o=0.
- Then four consecutive valid pulses -> waddr_o 1,2,3,4 in order, occupancy back to 0, singlecycle_o=1.
- One outstanding lat=3 op; enable lat=2 -> stall_type=1, perf_type_o=1, no request. Enable lat=3 -> also stalled.
- Entries {7,9} outstanding; read port 1 = 9 valid -> read_dep_o=1. Same cycle valid_i retires 7 -> still 1. Read = 7 with valid_i -> read_dep_o=0.
- valid_i with empty queue and no request -> err_o=1 next cycle and held, wvalid=0. Assert rst_ni mid-queue -> occupancy 0 and err_o 0 immediately.
